// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle for the multicycle RISC-V controller.
// The slave modport is the controller; the master modport is the datapath/bench side.
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       mem_ready;
   logic       mem_req;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [2:0] ImmSrc;
   logic       instr_done;
   logic       illegal;

   modport master (
      output op, funct3, funct7b5, Zero, mem_ready,
      input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal
   );

   modport slave (
      input  op, funct3, funct7b5, Zero, mem_ready,
      output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, illegal
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style multicycle controller for an RV32 subset (lw, sw, R/I ALU ops, beq, jal).
// Memory accesses stall on mem_ready; unknown opcodes park the FSM in HALT until reset.
module multicycle_controller #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input logic                   clk,
   input logic                   rst_n,
   multicycle_controller_if.slave bus
);

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecuteR,
      StExecuteI,
      StAluWb,
      StBeq,
      StJal,
      StHalt
   } state_e;

   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpRType = 7'b0110011;
   localparam logic [6:0] OpIType = 7'b0010011;
   localparam logic [6:0] OpBeq   = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;

   state_e     state_q, state_d;
   logic       rdy;
   logic [2:0] alu_funct;

   logic       mem_req_c, pc_write_c, mem_write_c, ir_write_c, reg_write_c, done_c;
   logic       adr_src_c;
   logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c;
   logic [2:0] alu_ctrl_c;

   // With waits disabled every access completes in its first cycle.
   assign rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

   // ALU operation selected by funct fields; only consumed in the execute states.
   always_comb begin
      alu_funct = 3'b000;
      unique case (bus.funct3)
         3'b000:  alu_funct = (bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000;
         3'b010:  alu_funct = 3'b101;
         3'b110:  alu_funct = 3'b011;
         3'b111:  alu_funct = 3'b010;
         default: alu_funct = 3'b000;
      endcase
   end

   // Immediate format follows the opcode in every state.
   always_comb begin
      bus.ImmSrc = 3'b000;
      unique case (bus.op)
         OpStore: bus.ImmSrc = 3'b001;
         OpBeq:   bus.ImmSrc = 3'b010;
         OpJal:   bus.ImmSrc = 3'b011;
         default: bus.ImmSrc = 3'b000;
      endcase
   end

   // State register; reset restarts at FETCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-state control outputs.
   always_comb begin
      state_d      = state_q;
      mem_req_c    = 1'b0;
      pc_write_c   = 1'b0;
      mem_write_c  = 1'b0;
      ir_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      done_c       = 1'b0;
      adr_src_c    = 1'b0;
      result_src_c = 2'b00;
      alu_src_a_c  = 2'b00;
      alu_src_b_c  = 2'b00;
      alu_ctrl_c   = 3'b000;

      unique case (state_q)
         StFetch: begin
            mem_req_c    = 1'b1;
            alu_src_b_c  = 2'b10;
            result_src_c = 2'b10;
            // PC+4 and the instruction are latched only when the fetch completes.
            pc_write_c   = rdy;
            ir_write_c   = rdy;
            if (rdy) state_d = StDecode;
         end
         StDecode: begin
            // Precompute OldPC + imm into ALUOut for beq/jal.
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b01;
            unique case (bus.op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = StExecuteR;
               OpIType:         state_d = StExecuteI;
               OpBeq:           state_d = StBeq;
               OpJal:           state_d = StJal;
               default:         state_d = StHalt;
            endcase
         end
         StMemAdr: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            state_d     = bus.op[5] ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            mem_req_c = 1'b1;
            adr_src_c = 1'b1;
            if (rdy) state_d = StMemWb;
         end
         StMemWb: begin
            result_src_c = 2'b01;
            reg_write_c  = 1'b1;
            done_c       = 1'b1;
            state_d      = StFetch;
         end
         StMemWrite: begin
            mem_req_c   = 1'b1;
            adr_src_c   = 1'b1;
            mem_write_c = 1'b1;
            done_c      = rdy;
            if (rdy) state_d = StFetch;
         end
         StExecuteR: begin
            alu_src_a_c = 2'b10;
            alu_ctrl_c  = alu_funct;
            state_d     = StAluWb;
         end
         StExecuteI: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            alu_ctrl_c  = alu_funct;
            state_d     = StAluWb;
         end
         StAluWb: begin
            reg_write_c = 1'b1;
            done_c      = 1'b1;
            state_d     = StFetch;
         end
         StBeq: begin
            alu_src_a_c = 2'b10;
            alu_ctrl_c  = 3'b001;
            pc_write_c  = bus.Zero;
            done_c      = 1'b1;
            state_d     = StFetch;
         end
         StJal: begin
            // Jump to the decode-time target while computing OldPC+4 for rd.
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b10;
            pc_write_c  = 1'b1;
            state_d     = StAluWb;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   // Strobes are gated by rst_n so they fall immediately when reset asserts.
   assign bus.mem_req    = mem_req_c & rst_n;
   assign bus.PCWrite    = pc_write_c & rst_n;
   assign bus.MemWrite   = mem_write_c & rst_n;
   assign bus.IRWrite    = ir_write_c & rst_n;
   assign bus.RegWrite   = reg_write_c & rst_n;
   assign bus.instr_done = done_c & rst_n;

   assign bus.AdrSrc     = adr_src_c;
   assign bus.ResultSrc  = result_src_c;
   assign bus.ALUSrcA    = alu_src_a_c;
   assign bus.ALUSrcB    = alu_src_b_c;
   assign bus.ALUControl = alu_ctrl_c;

   // HALT is absorbing until reset, so this flag is sticky.
   assign bus.illegal = (state_q == StHalt);

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1: 1 = honour mem_ready; 0 = treat mem_ready as always 1.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- op  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write.
- IRWrite  out  1  instruction/OldPC register enable.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = const 4.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- illegal  out  1  sticky illegal-opcode flag.

Function
REQ-003 SHALL implement a Moore FSM: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, HALT; one state register.
REQ-004 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
- IRWrite and PCWrite SHALL be 1 only in the cycle mem_ready=1; that cycle goes to DECODE, otherwise hold FETCH.
REQ-005 DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other -> HALT
REQ-006 MEMADR: ALUSrcA=10, ALUSrcB=01, add.
- Next MEMREAD if op[5]=0, else MEMWRITE.
REQ-007 MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00.
- Holds until mem_ready=1, then -> MEMWB.
REQ-008 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1 -> FETCH.
REQ-009 MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00.
- MemWrite=1 in every cycle mem_req is held; the write commits on the mem_ready=1 cycle.
- On that cycle: instr_done=1 -> FETCH.
REQ-010 EXECUTER: ALUSrcA=10, ALUSrcB=00. EXECUTEI: ALUSrcA=10, ALUSrcB=01. Both use funct decode and -> ALUWB.
REQ-011 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1 -> FETCH.
REQ-012 BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
- PCWrite=Zero (combinational), instr_done=1 -> FETCH.
REQ-013 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4 to rd).
REQ-014 HALT: all enables 0, mem_req=0, illegal=1; stays in HALT until reset.
REQ-015 ALU decode in funct-decode states:
- funct3 000: sub if funct7b5 & op[5], else add
- funct3 010: slt
- funct3 110: or
- funct3 111: and
- other funct3: add
REQ-016 ImmSrc SHALL be decoded combinationally from op in every state:
- 0100011 -> 001
- 1100011 -> 010
- 1101111 -> 011
- otherwise 000
REQ-017 Outside the states listed in REQ-004 to REQ-014, each enable SHALL be 0; mux selects are don't-care but driven to 0.
REQ-018 mem_ready SHALL be ignored in states with mem_req=0.
REQ-019 Instruction latency with zero wait states:
- lw 5 cycles
- sw 4 cycles
- R-type/I-type 4 cycles
- beq 3 cycles
- jal 4 cycles
- Each wait cycle adds 1.

Reset
REQ-020 rst_n low SHALL asynchronously force the state to FETCH and clear illegal.
REQ-021 While rst_n is low, SHALL force PCWrite, IRWrite, MemWrite, RegWrite, mem_req and instr_done to 0.
REQ-022 The first FETCH request SHALL occur in the first clk edge cycle after rst_n deasserts.
REQ-023 Reset asserted mid-instruction SHALL abandon the instruction with no further write strobes.

Verification
REQ-024 Scenario: add (op 0110011, funct3 000, funct7b5 0), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000; RegWrite=1 only in cycle 4.
REQ-025 Scenario: lw with mem_ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles with mem_req=1, AdrSrc=1; MEMWB follows; total 7 cycles.
REQ-026 Scenario: beq, once with Zero=1 and once with Zero=0 -> PCWrite=1 in cycle 3 only when Zero=1; ALUControl=001; ImmSrc=010.
REQ-027 Scenario: jal -> PCWrite in cycles 1 and 3; ALUWB RegWrite in cycle 4; ImmSrc=011.
REQ-028 Scenario: op 1111111 -> DECODE then HALT; illegal=1 held; mem_req=0 for 10 cycles; rst_n pulse clears illegal and restarts FETCH.
REQ-029 Scenario: rst_n asserted during MEMWRITE wait -> MemWrite and mem_req drop immediately (asynchronously); state is FETCH after release.
